// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch unit bus: redirects, stall, imem handshake, decode outputs
interface pc_fetch_unit_if;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        misaligned;

  modport master (
    output pc_plus4, branch_taken, branch_target, jump, jump_target,
           stall, imem_ack, imem_data,
    input  pc, imem_req, inst, inst_valid, inst_pc, misaligned
  );

  modport slave (
    input  pc_plus4, branch_taken, branch_target, jump, jump_target,
           stall, imem_ack, imem_data,
    output pc, imem_req, inst, inst_valid, inst_pc, misaligned
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC sequencing and instruction fetch with redirect, stall buffer and flush
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, FETCH, BUFFERED} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_imem_req;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;
  logic        r_misaligned;
  logic        r_pend;
  logic [31:0] r_pend_target;
  logic [31:0] r_buf;
  logic [31:0] r_buf_pc;

  logic        w_redirect;
  logic [31:0] w_sel_target;
  logic [31:0] w_fix_target;
  logic        w_fix_mis;
  logic [31:0] w_next_pc;

  assign w_redirect   = bus.jump | bus.branch_taken;
  assign w_sel_target = bus.jump ? bus.jump_target : bus.branch_target;
  // A redirect arriving this cycle beats one latched while waiting for ack
  assign w_fix_target = w_redirect ? w_sel_target : r_pend_target;
  assign w_fix_mis    = |w_fix_target[1:0];
  assign w_next_pc    = w_fix_mis ? EXC_VECTOR : w_fix_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_VECTOR;
      r_imem_req    <= 1'b0;
      r_inst        <= 32'h0;
      r_inst_pc     <= 32'h0;
      r_inst_valid  <= 1'b0;
      r_misaligned  <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_target <= 32'h0;
      r_buf         <= 32'h0;
      r_buf_pc      <= 32'h0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        BOOT: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (!bus.imem_ack) begin
            if (w_redirect) begin
              r_pend        <= 1'b1;
              r_pend_target <= w_sel_target;
            end
            if (w_redirect || !bus.stall) r_inst_valid <= 1'b0;
          end else if (w_redirect || r_pend) begin
            r_pc         <= w_next_pc;
            r_misaligned <= w_fix_mis;
            r_pend       <= 1'b0;
            r_inst_valid <= 1'b0;
          end else if (!bus.stall) begin
            r_inst       <= bus.imem_data;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
            r_pc         <= bus.pc_plus4;
          end else begin
            // Decode is stalled: park the word and stop requesting
            r_buf      <= bus.imem_data;
            r_buf_pc   <= r_pc;
            r_pc       <= bus.pc_plus4;
            r_state    <= BUFFERED;
            r_imem_req <= 1'b0;
          end
        end
        BUFFERED: begin
          if (w_redirect) begin
            r_pc         <= w_next_pc;
            r_misaligned <= w_fix_mis;
            r_inst_valid <= 1'b0;
            r_state      <= FETCH;
            r_imem_req   <= 1'b1;
          end else if (!bus.stall) begin
            r_inst       <= r_buf;
            r_inst_pc    <= r_buf_pc;
            r_inst_valid <= 1'b1;
            r_state      <= FETCH;
            r_imem_req   <= 1'b1;
          end
        end
        default: begin
          r_state    <= BOOT;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc         = r_pc;
  assign bus.imem_req   = r_imem_req;
  assign bus.inst       = r_inst;
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst_pc    = r_inst_pc;
  assign bus.misaligned = r_misaligned;

endmodule
